// File: rtl/alu.sv
// Execute-stage ALU with a single output register stage.
// Out carries the primary result, R the secondary one, and signFlag the sign of the signed result.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Operation,
  output logic             signFlag,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] R
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LBU  = 3'b110;
  localparam logic [2:0] OP_ADDU = 3'b111;

  logic [WIDTH:0]          sum_ext;
  logic [WIDTH-1:0]        diff;
  logic signed [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_div;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] r_next;
  logic             sign_next;

  assign sum_ext = {1'b0, A} + {1'b0, B};
  assign diff    = A - B;
  assign prod    = $signed(A) * $signed(B);

  // Signed division is done on magnitudes. The most negative dividend maps to its own
  // unsigned magnitude, so 0x8000 / -1 wraps back to 0x8000 without special handling.
  assign a_mag    = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag    = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign div_zero = (B == '0);
  assign b_div    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag    = a_mag / b_div;
  assign r_mag    = a_mag % b_div;
  assign quot     = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
  assign rem      = A[WIDTH-1] ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    out_next  = '0;
    r_next    = '0;
    sign_next = 1'b0;
    case (Operation)
      OP_ADD: begin
        out_next  = sum_ext[WIDTH-1:0];
        sign_next = sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        out_next  = diff;
        sign_next = diff[WIDTH-1];
      end
      OP_MUL: begin
        out_next  = prod[WIDTH-1:0];
        r_next    = prod[2*WIDTH-1:WIDTH];
        sign_next = prod[2*WIDTH-1];
      end
      OP_DIV: begin
        if (div_zero) begin
          out_next = '1;
          r_next   = A;
        end else begin
          out_next  = quot;
          r_next    = rem;
          sign_next = quot[WIDTH-1];
        end
      end
      OP_AND:  out_next = A & B;
      OP_OR:   out_next = A | B;
      OP_LBU:  out_next = {{(WIDTH-8){1'b0}}, B[7:0]};
      OP_ADDU: begin
        out_next = sum_ext[WIDTH-1:0];
        r_next   = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      end
      default: begin
        out_next  = 'x;
        r_next    = 'x;
        sign_next = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out      <= '0;
      R        <= '0;
      signFlag <= 1'b0;
    end else begin
      Out      <= out_next;
      R        <= r_next;
      signFlag <= sign_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer reference model, directed literal cases,
// reset behaviour and randomized back-to-back traffic.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  op = '0;
  logic        sign_flag;
  logic [15:0] out_q;
  logic [15:0] r_q;

  int tests = 0;
  int fails = 0;

  alu #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(a),
    .B(b),
    .Operation(op),
    .signFlag(sign_flag),
    .Out(out_q),
    .R(r_q)
  );

  always #5 clk = ~clk;

  // Reference model computed with plain 32/64-bit integer arithmetic.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] mop,
                                output logic [15:0] eo, output logic [15:0] er, output logic es);
    int     sa;
    int     sb;
    int     q;
    int     rm;
    int     u;
    longint p;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    eo = '0;
    er = '0;
    es = 1'b0;
    case (mop)
      3'd0: begin u = sa + sb; eo = u[15:0]; es = (sa + sb) < 0 ? (u[15] == 1'b1) : u[15]; end
      3'd1: begin u = sa - sb; eo = u[15:0]; es = u[15]; end
      3'd2: begin p = longint'(sa) * longint'(sb); eo = p[15:0]; er = p[31:16]; es = (p < 0); end
      3'd3: begin
        if (mb == 16'd0) begin
          eo = 16'hFFFF; er = ma; es = 1'b0;
        end else begin
          q = sa / sb; rm = sa % sb;
          eo = q[15:0]; er = rm[15:0]; es = eo[15];
        end
      end
      3'd4: eo = ma & mb;
      3'd5: eo = ma | mb;
      3'd6: eo = {8'h00, mb[7:0]};
      default: begin u = int'(ma) + int'(mb); eo = u[15:0]; er = (u > 65535) ? 16'd1 : 16'd0; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (A=%h B=%h op=%0d) at %0t", name, act, exp, a, b, op, $time);
    end
  endtask

  // Compare process: every edge taken out of reset is checked against the model.
  always begin
    logic [15:0] ca, cb, eo, er;
    logic [2:0]  cop;
    logic        es;
    @(posedge clk);
    if (rst_n === 1'b1) begin
      ca = a; cb = b; cop = op;
      #1;
      if (rst_n === 1'b1) begin
        model(ca, cb, cop, eo, er, es);
        chk("model_out", out_q, eo);
        chk("model_r", r_q, er);
        chk("model_sign", {15'd0, sign_flag}, {15'd0, es});
        $display("[TB] op=%0d A=%h B=%h -> Out=%h R=%h signFlag=%b", cop, ca, cb, out_q, r_q, sign_flag);
      end
    end
  end

  task automatic run(input string name, input logic [15:0] ta, input logic [15:0] tbv, input logic [2:0] top,
                     input logic [15:0] eo, input logic [15:0] er, input logic es);
    @(negedge clk);
    a = ta; b = tbv; op = top;
    @(posedge clk);
    #2;
    chk({name, "_out"}, out_q, eo);
    chk({name, "_r"}, r_q, er);
    chk({name, "_sign"}, {15'd0, sign_flag}, {15'd0, es});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_out"}, out_q, 16'd0);
    chk({name, "_r"}, r_q, 16'd0);
    chk({name, "_sign"}, {15'd0, sign_flag}, 16'd0);
  endtask

  logic [15:0] specials [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h00FF};

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    // Asynchronous reset with arbitrary inputs, checked between clock edges.
    a = 16'h1234; b = 16'h0F0F; op = 3'd2;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    @(negedge clk);
    chk_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    run("add_2_2",    16'd2,      16'd2,      3'd0, 16'd4,      16'd0,      1'b0);
    run("add_2_m4",   16'd2,      16'hFFFC,   3'd0, 16'hFFFE,   16'd0,      1'b1);
    run("sub_m4_m2",  16'hFFFC,   16'hFFFE,   3'd1, 16'hFFFE,   16'd0,      1'b1);
    run("sub_2_2",    16'd2,      16'd2,      3'd1, 16'd0,      16'd0,      1'b0);
    run("mul_m1_m1",  16'hFFFF,   16'hFFFF,   3'd2, 16'd1,      16'd0,      1'b0);
    run("mul_5_8",    16'd5,      16'd8,      3'd2, 16'd40,     16'd0,      1'b0);
    run("mul_300",    16'd300,    16'd300,    3'd2, 16'h5F90,   16'd1,      1'b0);
    run("mul_neg",    16'hFFFE,   16'd3,      3'd2, 16'hFFFA,   16'hFFFF,   1'b1);
    run("div_10_5",   16'd10,     16'd5,      3'd3, 16'd2,      16'd0,      1'b0);
    run("div_13_3",   16'd13,     16'd3,      3'd3, 16'd4,      16'd1,      1'b0);
    run("div_m7_2",   16'hFFF9,   16'd2,      3'd3, 16'hFFFD,   16'hFFFF,   1'b1);
    run("div_7_m2",   16'd7,      16'hFFFE,   3'd3, 16'hFFFD,   16'd1,      1'b1);
    run("div_zero",   16'h1234,   16'd0,      3'd3, 16'hFFFF,   16'h1234,   1'b0);
    run("div_ovf",    16'h8000,   16'hFFFF,   3'd3, 16'h8000,   16'd0,      1'b1);
    run("and",        16'd255,    16'd15,     3'd4, 16'd15,     16'd0,      1'b0);
    run("or",         16'd10,     16'd5,      3'd5, 16'd15,     16'd0,      1'b0);
    run("lbu",        16'hABCD,   16'h1285,   3'd6, 16'h0085,   16'd0,      1'b0);
    run("addu_carry", 16'hFFFF,   16'd1,      3'd7, 16'd0,      16'd1,      1'b0);
    run("addu_nc",    16'h1000,   16'h0234,   3'd7, 16'h1234,   16'd0,      1'b0);

    // Reset mid-stream: the op sampled while rst_n is low must be discarded.
    run("pre_reset",  16'd300,    16'd300,    3'd2, 16'h5F90,   16'd1,      1'b0);
    @(negedge clk);
    a = 16'd7; b = 16'd9; op = 3'd0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst_clear");
    @(posedge clk);
    #1 chk_zero("midrst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("midrst_release");
    @(posedge clk);
    #2;
    chk("post_reset_out", out_q, 16'd16);

    // Back-to-back sweep over every opcode, then random traffic.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      a = pick(); b = pick(); op = 3'(i % 8);
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      a = pick(); b = pick(); op = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
